cache_axi_read_arbiter: RTL and testbench
=========================================

# cache_axi_read_arbiter

Shares the single AXI4 read-address/read-data channel of the CPU's bus interface between the instruction cache and the data cache line-refill engines. Each cache issues whole-line burst reads; the arbiter grants one requester at a time, holds the grant until the burst's last beat completes, and returns data only to the owner. It sits between both caches' `m_ar*`/`m_r*` ports and the AXI crossbar master port; write channels bypass it.

## Interface

**Parameters**
- `INST_ID`, default 4'd0: ARID driven for instruction-cache bursts.
- `DATA_ID`, default 4'd1: ARID driven for data-cache bursts.

**Ports** (prefix `i_` is the I-cache side, `d_` the D-cache side, `m_` the AXI side)
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-low reset (`RST_ENABLE` = 0).
- `i_araddr`/`d_araddr` in 32: line-aligned burst start address.
- `i_arlen`/`d_arlen` in 8: beats minus 1. I-cache is 7; D-cache is 15.
- `i_arvalid`/`d_arvalid` in 1: request valid.
- `i_arready`/`d_arready` out 1: one-cycle acceptance pulse.
- `i_rdata`/`d_rdata` out 32: read beat.
- `i_rvalid`/`d_rvalid`, `i_rlast`/`d_rlast` out 1: beat qualifiers.
- `i_rready`/`d_rready` in 1: beat acceptance.
- `m_arid` out 4, `m_araddr` out 32, `m_arlen` out 8.
- `m_arsize` out 3, constant 3'b010.
- `m_arburst` out 2, constant 2'b01.
- `m_arvalid` out 1, `m_arready` in 1.
- `m_rid` in 4, `m_rdata` in 32, `m_rvalid` in 1, `m_rlast` in 1, `m_rready` out 1.
- `busy` out 1: a grant is outstanding.
- `err` out 1: sticky flag, see Operation.

## Operation

**States:** ARB_IDLE, ARB_ADDR, ARB_DATA.

**ARB_IDLE**
- If any `*_arvalid` is set, pick a winner and latch its addr, len, and ID into registers.
- Pulse the winner's `*_arready` in the same cycle.
- Record `grant` (INST/DATA) and load `beat_cnt` = 0.
- Go to ARB_ADDR.

**ARB_ADDR**
- `m_arvalid`=1, and `m_ar*` are driven from the latched registers.
- Stay until `m_arvalid && m_arready`, then go to ARB_DATA.

**ARB_DATA**
- Route `m_rdata`, `m_rvalid`, and `m_rlast` to the granted side.
- The other side sees `rvalid`/`rlast` = 0 and `rdata` = 0.
- `m_rready` = granted side's `rready`.
- On each handshake, increment `beat_cnt` (8-bit, no wrap in legal use).
- On a handshake with `m_rlast`=1, go to ARB_IDLE and update `last_grant`.

**Winner selection**
- Fixed priority: DATA wins when both request (load/store miss stalls the pipeline harder).
- Round-robin applies instead when the macro in Configuration is defined.

**err is set (sticky until reset) when, during a handshake:**
- `m_rid` ≠ latched ID; or
- `m_rlast`=1 with `beat_cnt` ≠ latched len; or
- `m_rlast`=0 with `beat_cnt` = latched len.

A beat that sets `err` is still forwarded normally.

**Requester rules**
- A requester must hold `*_arvalid` until it sees its `*_arready`.
- A requester holding `*_arvalid` while the other is granted just waits; there is no starvation bound under fixed priority.

**Reset**
- Every output is 0 except the constants (`m_arsize`, `m_arburst`).
- `m_arid`, `m_araddr`, and `m_arlen` are 0.
- State → ARB_IDLE, `grant` cleared, `last_grant` = INST, `err` = 0.
- Reset mid-burst abandons the burst. The AXI slave is reset by the same `rst`.

## Timing

- Request seen in cycle N (IDLE) → `*_arready` pulse in N → `m_arvalid` high in N+1.
- `m_arvalid` stays high until `m_arready`.
- The R path is combinational: `*_rvalid` appears in the same cycle as `m_rvalid`, with zero added latency.
- The `rlast` beat completes in cycle M; the earliest next grant is M+1 (IDLE), and its `m_arvalid` is at M+2.
- `m_arready` arriving in the same cycle `m_arvalid` rises completes the address phase in one cycle.
- `busy` = (state ≠ ARB_IDLE), registered.

## Configuration

`ARB_ROUND_ROBIN_EN`:
- **Defined:** on a simultaneous request, the side not in `last_grant` wins. Since `last_grant` resets to INST, the first tie goes to DATA, the next tie to INST, and so on.
- **Undefined:** fixed DATA-over-INST priority; `last_grant` still exists but is unused for selection.

## Structure

- `defines.vh` holds:
  - state encodings `ARB_IDLE`=2'd0, `ARB_ADDR`=2'd1, `ARB_DATA`=2'd2;
  - grant encodings `GRANT_INST`=1'b0, `GRANT_DATA`=1'b1;
  - `RST_ENABLE`/`RST_DISABLE`;
  - AXI constants `AXI_SIZE_4B`, `AXI_BURST_INCR`.
- One sub-module, `arb_grant_picker`: combinational winner from `i_arvalid`, `d_arvalid`, and `last_grant`, with the macro applied inside it only.

## Test plan

1. **Only the I-cache requests.**
   - Stimulus: `i_araddr`=0xBFC0_0040, `i_arlen`=7; the slave returns 8 beats, the last with rlast.
   - Required: `m_arid`=0 and `m_arlen`=7; `i_rvalid` pulses 8 times; `d_rvalid` stays 0; `err`=0; back in IDLE.
2. **Simultaneous requests, macro undefined.**
   - Stimulus: `d_araddr`=0x8000_0100 (len 15) and `i_araddr`=0xBFC0_0000 (len 7).
   - Required: the DATA burst is granted first (`m_arid`=1, 16 beats); INST is granted only after its `rlast` (M+2 `m_arvalid`).
3. **Macro defined, two consecutive tie rounds.**
   - Required: grant order DATA, INST, DATA, INST.
4. **Backpressure.**
   - Stimulus: `d_rready` toggles 0/1 each cycle during a 16-beat burst.
   - Required: `m_rready` mirrors `d_rready`; exactly 16 handshakes; `beat_cnt` reaches 15 on `rlast`.
5. **Protocol faults.**
   - Stimulus: the slave asserts `m_rlast` on beat 5 of an 8-beat burst; separately, it returns `m_rid`=1 for an INST grant.
   - Required: `err`=1 in the cycle after each fault and held; data is still forwarded.
6. **Reset mid-burst.**
   - Stimulus: `rst`=0 during ARB_DATA beat 3.
   - Required: next cycle all outputs are 0 and `busy`=0; after release, a new I-cache request is accepted normally.

Source files
------------

// File: rtl/cache_axi_read_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cache_axi_read_arbiter_pkg
// Shared types and constants for the I/D-cache AXI read arbiter: FSM state
// encoding, grant encoding, reset polarity and the fixed AXI burst attributes.
// ----------------------------------------------------------------------------
package cache_axi_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_e;

    // rst is active-low
    localparam logic RST_ENABLE  = 1'b0;
    localparam logic RST_DISABLE = 1'b1;

    // Every refill beat is one 32-bit word in an incrementing burst
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/cache_axi_read_arbiter_if.sv
// ----------------------------------------------------------------------------
// cache_axi_read_arbiter_if
// Bundles the I-cache (i_*), D-cache (d_*) and AXI master (m_*) read-channel
// signals plus the busy/err status of the arbiter.
//   master : arbiter view (drives arready/r* to caches, ar*/rready to AXI)
//   slave  : environment view (caches and AXI slave)
// ----------------------------------------------------------------------------
interface cache_axi_read_arbiter_if;

    // I-cache side
    logic [31:0] i_araddr;
    logic [7:0]  i_arlen;
    logic        i_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_rlast;
    logic        i_rready;

    // D-cache side
    logic [31:0] d_araddr;
    logic [7:0]  d_arlen;
    logic        d_arvalid;
    logic        d_arready;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_rlast;
    logic        d_rready;

    // AXI master side
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [3:0]  m_rid;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_rlast;
    logic        m_rready;

    // Status
    logic        busy;
    logic        err;

    modport master (
        input  i_araddr, i_arlen, i_arvalid, i_rready,
        output i_arready, i_rdata, i_rvalid, i_rlast,
        input  d_araddr, d_arlen, d_arvalid, d_rready,
        output d_arready, d_rdata, d_rvalid, d_rlast,
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        input  m_arready,
        input  m_rid, m_rdata, m_rvalid, m_rlast,
        output m_rready,
        output busy, err
    );

    modport slave (
        output i_araddr, i_arlen, i_arvalid, i_rready,
        input  i_arready, i_rdata, i_rvalid, i_rlast,
        output d_araddr, d_arlen, d_arvalid, d_rready,
        input  d_arready, d_rdata, d_rvalid, d_rlast,
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        output m_arready,
        output m_rid, m_rdata, m_rvalid, m_rlast,
        input  m_rready,
        input  busy, err
    );

endinterface

// File: rtl/cache_axi_read_arbiter_grant_picker.sv
// ----------------------------------------------------------------------------
// arb_grant_picker
// Combinational winner selection between the two refill requesters.
// Build option: ARB_ROUND_ROBIN_EN
//   defined   - on a tie, the side that did not own the previous burst wins
//   undefined - on a tie, DATA always wins (fixed priority)
// Ports:
//   i_arvalid_i, d_arvalid_i : request lines from I- and D-cache
//   last_grant_i             : owner of the most recently completed burst
//   req_any_o                : at least one request pending
//   winner_o                 : selected requester (valid when req_any_o)
// ----------------------------------------------------------------------------
module arb_grant_picker
    import cache_axi_read_arbiter_pkg::*;
(
    input  logic   i_arvalid_i,
    input  logic   d_arvalid_i,
    input  grant_e last_grant_i,
    output logic   req_any_o,
    output grant_e winner_o
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    assign req_any_o = i_arvalid_i | d_arvalid_i;

    always_comb begin
        winner_o = GRANT_INST;
        if (i_arvalid_i && d_arvalid_i) begin
            if (RR_EN)
                winner_o = (last_grant_i == GRANT_INST) ? GRANT_DATA : GRANT_INST;
            else
                winner_o = GRANT_DATA;
        end else if (d_arvalid_i) begin
            winner_o = GRANT_DATA;
        end
    end

endmodule

// File: rtl/cache_axi_read_arbiter.sv
// ----------------------------------------------------------------------------
// cache_axi_read_arbiter
// Shares one AXI4 read address/data channel between the I-cache and D-cache
// line-refill engines. One burst is outstanding at a time; the grant is held
// until the last beat handshakes and R data is routed only to the owner.
// Build option: ARB_ROUND_ROBIN_EN (tie-break policy, see arb_grant_picker).
// Parameters:
//   INST_ID, DATA_ID : ARID used for I-cache / D-cache bursts
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-low reset
//   bus  : cache_axi_read_arbiter_if.master (cache, AXI and status signals)
//
// state    | meaning
// ARB_IDLE | no grant; pick a winner, pulse its arready, latch addr/len/id
// ARB_ADDR | m_arvalid high with latched request until m_arready
// ARB_DATA | R channel routed to owner until the rlast handshake
// ----------------------------------------------------------------------------
module cache_axi_read_arbiter
    import cache_axi_read_arbiter_pkg::*;
#(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic                     clk,
    input  logic                     rst,
    cache_axi_read_arbiter_if.master bus
);

    arb_state_e  state_q, state_d;
    grant_e      grant_q, grant_d;
    grant_e      last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic        err_q, err_d;
    logic        busy_q;

    logic        req_any;
    grant_e      winner;
    logic        r_hs;

    arb_grant_picker u_picker (
        .i_arvalid_i  (bus.i_arvalid),
        .d_arvalid_i  (bus.d_arvalid),
        .last_grant_i (last_grant_q),
        .req_any_o    (req_any),
        .winner_o     (winner)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q      <= ARB_IDLE;
            grant_q      <= GRANT_INST;
            last_grant_q <= GRANT_INST;
            addr_q       <= '0;
            len_q        <= '0;
            id_q         <= '0;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            id_q         <= id_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
            busy_q       <= (state_d != ARB_IDLE);
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        addr_d        = addr_q;
        len_d         = len_q;
        id_d          = id_q;
        beat_cnt_d    = beat_cnt_q;
        err_d         = err_q;
        r_hs          = 1'b0;
        bus.i_arready = 1'b0;
        bus.d_arready = 1'b0;
        bus.m_arvalid = 1'b0;
        bus.m_rready  = 1'b0;
        bus.i_rdata   = '0;
        bus.i_rvalid  = 1'b0;
        bus.i_rlast   = 1'b0;
        bus.d_rdata   = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_rlast   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // Gate acceptance with rst so a request held through reset
                // is not acknowledged and then dropped by the register clear.
                if (req_any && (rst == RST_DISABLE)) begin
                    grant_d    = winner;
                    beat_cnt_d = '0;
                    state_d    = ARB_ADDR;
                    if (winner == GRANT_DATA) begin
                        addr_d        = bus.d_araddr;
                        len_d         = bus.d_arlen;
                        id_d          = DATA_ID;
                        bus.d_arready = 1'b1;
                    end else begin
                        addr_d        = bus.i_araddr;
                        len_d         = bus.i_arlen;
                        id_d          = INST_ID;
                        bus.i_arready = 1'b1;
                    end
                end
            end

            ARB_ADDR: begin
                bus.m_arvalid = 1'b1;
                if (bus.m_arready)
                    state_d = ARB_DATA;
            end

            ARB_DATA: begin
                if (grant_q == GRANT_DATA) begin
                    bus.d_rdata  = bus.m_rdata;
                    bus.d_rvalid = bus.m_rvalid;
                    bus.d_rlast  = bus.m_rlast;
                    bus.m_rready = bus.d_rready;
                    r_hs         = bus.m_rvalid && bus.d_rready;
                end else begin
                    bus.i_rdata  = bus.m_rdata;
                    bus.i_rvalid = bus.m_rvalid;
                    bus.i_rlast  = bus.m_rlast;
                    bus.m_rready = bus.i_rready;
                    r_hs         = bus.m_rvalid && bus.i_rready;
                end

                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // beat_cnt_q is the index of the current beat, so the
                    // last beat must arrive exactly when it equals len.
                    if ((bus.m_rid != id_q) ||
                        ( bus.m_rlast && (beat_cnt_q != len_q)) ||
                        (!bus.m_rlast && (beat_cnt_q == len_q)))
                        err_d = 1'b1;
                    if (bus.m_rlast) begin
                        state_d      = ARB_IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    assign bus.m_arid    = id_q;
    assign bus.m_araddr  = addr_q;
    assign bus.m_arlen   = len_q;
    assign bus.m_arsize  = AXI_SIZE_4B;
    assign bus.m_arburst = AXI_BURST_INCR;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_cache_axi_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_axi_read_arbiter
// Directed bench: expected grants (side/addr/len) are queued when requests
// are raised and popped when the AXI address phase appears. Beat data is
// addr + 4*index and is checked on the owning side each cycle.
// ----------------------------------------------------------------------------
module tb_cache_axi_read_arbiter;

    typedef struct {
        logic        side;   // 0 = INST, 1 = DATA
        logic [31:0] addr;
        logic [7:0]  len;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_axi_read_arbiter_if bus ();

    cache_axi_read_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int   vectors    = 0;
    int   miscompares = 0;
    txn_t sb[$];
    logic last_g     = 1'b0;
    logic err_model  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
        return (last_g == 1'b1) ? 1'b0 : 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    // Advance one clock; a requester drops arvalid after seeing its arready.
    task automatic step();
        logic ia, da;
        #1;
        ia = bus.i_arready;
        da = bus.d_arready;
        @(posedge clk);
        #1;
        if (ia) bus.i_arvalid = 1'b0;
        if (da) bus.d_arvalid = 1'b0;
    endtask

    task automatic push(input logic side, input logic [31:0] addr, input logic [7:0] len);
        txn_t t;
        t.side = side; t.addr = addr; t.len = len;
        sb.push_back(t);
    endtask

    task automatic request(input logic side, input logic [31:0] addr, input logic [7:0] len);
        if (side) begin
            bus.d_araddr = addr; bus.d_arlen = len; bus.d_arvalid = 1'b1;
        end else begin
            bus.i_araddr = addr; bus.i_arlen = len; bus.i_arvalid = 1'b1;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_i_arready", bus.i_arready, 0);
        chk("rst_d_arready", bus.d_arready, 0);
        chk("rst_m_arvalid", bus.m_arvalid, 0);
        chk("rst_m_arid",    bus.m_arid,    0);
        chk("rst_m_araddr",  bus.m_araddr,  0);
        chk("rst_m_arlen",   bus.m_arlen,   0);
        chk("rst_m_arsize",  bus.m_arsize,  3'b010);
        chk("rst_m_arburst", bus.m_arburst, 2'b01);
        chk("rst_i_rvalid",  bus.i_rvalid,  0);
        chk("rst_i_rdata",   bus.i_rdata,   0);
        chk("rst_i_rlast",   bus.i_rlast,   0);
        chk("rst_d_rvalid",  bus.d_rvalid,  0);
        chk("rst_d_rdata",   bus.d_rdata,   0);
        chk("rst_d_rlast",   bus.d_rlast,   0);
        chk("rst_m_rready",  bus.m_rready,  0);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_err",       bus.err,       0);
    endtask

    // Wait for the grant pulse, then run the address phase with ready_delay
    // stall cycles before m_arready.
    task automatic addr_phase(input int ready_delay, output txn_t t, output bit ok);
        int n = 0;
        ok = 1'b0;
        t.side = 1'b0; t.addr = '0; t.len = '0;
        #1;
        while (!(bus.i_arready || bus.d_arready) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            chk("ar_timeout", 0, 1);
            return;
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        t = sb.pop_front();
        chk("arready_d", bus.d_arready, t.side);
        chk("arready_i", bus.i_arready, !t.side);
        chk("arvalid_in_idle", bus.m_arvalid, 0);
        step();
        chk("m_arvalid", bus.m_arvalid, 1);
        chk("busy", bus.busy, 1);
        chk("m_arid", bus.m_arid, t.side ? 4'd1 : 4'd0);
        chk("m_araddr", bus.m_araddr, t.addr);
        chk("m_arlen", bus.m_arlen, t.len);
        chk("m_arsize", bus.m_arsize, 3'b010);
        chk("m_arburst", bus.m_arburst, 2'b01);
        for (int i = 0; i < ready_delay; i++) begin
            step();
            chk("m_arvalid_hold", bus.m_arvalid, 1);
        end
        bus.m_arready = 1'b1;
        step();
        bus.m_arready = 1'b0;
        ok = 1'b1;
    endtask

    // Slave returns beats; rlast on index rlast_at, wrong ID on bad_rid_at.
    // stop_at >= 0 returns with that beat driven but not yet clocked.
    task automatic burst(input txn_t t, input int rlast_at, input int bad_rid_at,
                         input bit toggle, input int stop_at, output int hs);
        int       k   = 0;
        int       cyc = 0;
        logic     rr;
        logic [3:0] id;
        logic     bad;
        id = t.side ? 4'd1 : 4'd0;
        hs = 0;
        while (cyc < 100) begin
            rr = toggle ? ((cyc % 2) == 0) : 1'b1;
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = t.addr + 32'(4 * k);
            bus.m_rlast  = (k == rlast_at);
            bus.m_rid    = (k == bad_rid_at) ? (id ^ 4'd1) : id;
            if (t.side) begin bus.d_rready = rr; bus.i_rready = 1'b1; end
            else        begin bus.i_rready = rr; bus.d_rready = 1'b1; end
            #1;
            if (t.side) begin
                chk("d_rvalid", bus.d_rvalid, 1);
                chk("d_rdata",  bus.d_rdata,  t.addr + 32'(4 * k));
                chk("d_rlast",  bus.d_rlast,  k == rlast_at);
                chk("i_rvalid_idle", bus.i_rvalid, 0);
                chk("i_rdata_idle",  bus.i_rdata,  0);
            end else begin
                chk("i_rvalid", bus.i_rvalid, 1);
                chk("i_rdata",  bus.i_rdata,  t.addr + 32'(4 * k));
                chk("i_rlast",  bus.i_rlast,  k == rlast_at);
                chk("d_rvalid_idle", bus.d_rvalid, 0);
                chk("d_rdata_idle",  bus.d_rdata,  0);
            end
            chk("m_rready", bus.m_rready, rr);
            if (k == stop_at) return;
            if (rr) chk("beat_cnt", dut.beat_cnt_q, k);
            bad = (k == bad_rid_at) || ((k == rlast_at) != (k == int'(t.len)));
            step();
            if (rr) begin
                hs++;
                if (bad) err_model = 1'b1;
                chk("err", bus.err, err_model);
                if (k == rlast_at) break;
                k++;
            end
            cyc++;
        end
        if (cyc >= 100) chk("burst_timeout", 0, 1);
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
    endtask

    task automatic serve(input int ready_delay);
        txn_t t;
        bit   ok;
        int   hs;
        addr_phase(ready_delay, t, ok);
        if (!ok) return;
        burst(t, int'(t.len), -1, 1'b0, -1, hs);
        chk("beats", hs, int'(t.len) + 1);
        last_g = t.side;
    endtask

    task automatic tie_round(input logic [31:0] ia, input logic [31:0] da);
        logic w;
        w = tie_winner();
        push(w, w ? da : ia, w ? 8'd15 : 8'd7);
        push(!w, w ? ia : da, w ? 8'd7 : 8'd15);
        request(1'b0, ia, 8'd7);
        request(1'b1, da, 8'd15);
        serve(1);
        serve(0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.m_arready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b1;
        last_g = 1'b0;
        err_model = 1'b0;
        sb.delete();
    endtask

    initial begin
        txn_t t;
        bit   ok;
        int   hs;

        rst = 1'b0;
        bus.i_araddr = '0; bus.i_arlen = '0; bus.i_arvalid = 1'b0; bus.i_rready = 1'b1;
        bus.d_araddr = '0; bus.d_arlen = '0; bus.d_arvalid = 1'b0; bus.d_rready = 1'b1;
        bus.m_arready = 1'b0; bus.m_rid = '0; bus.m_rdata = '0;
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
        do_reset();

        // 1: I-cache alone
        push(1'b0, 32'hBFC0_0040, 8'd7);
        request(1'b0, 32'hBFC0_0040, 8'd7);
        serve(0);
        #1;
        chk("t1_err", bus.err, 0);
        chk("t1_busy", bus.busy, 0);

        // 2/3: simultaneous requests, three tie rounds
        tie_round(32'hBFC0_0000, 32'h8000_0100);
        tie_round(32'hBFC0_0100, 32'h8000_0200);
        tie_round(32'hBFC0_0200, 32'h8000_0300);

        // Tie right after a DATA-only burst separates the two policies
        push(1'b1, 32'h8000_0400, 8'd15);
        request(1'b1, 32'h8000_0400, 8'd15);
        serve(0);
        tie_round(32'hBFC0_0300, 32'h8000_0500);

        // 4: backpressure on a 16-beat DATA burst
        push(1'b1, 32'h8000_0600, 8'd15);
        request(1'b1, 32'h8000_0600, 8'd15);
        addr_phase(0, t, ok);
        if (ok) begin
            burst(t, 15, -1, 1'b1, -1, hs);
            chk("t4_handshakes", hs, 16);
        end
        #1;
        chk("t4_err", bus.err, 0);

        // 5a: early rlast on the fifth beat of an 8-beat burst
        push(1'b0, 32'hBFC0_0800, 8'd7);
        request(1'b0, 32'hBFC0_0800, 8'd7);
        addr_phase(0, t, ok);
        if (ok) begin
            burst(t, 4, -1, 1'b0, -1, hs);
            chk("t5a_handshakes", hs, 5);
        end
        repeat (3) step();
        chk("t5a_err_held", bus.err, 1);
        chk("t5a_busy", bus.busy, 0);
        do_reset();

        // 5b: wrong RID on an INST burst
        push(1'b0, 32'hBFC0_0900, 8'd7);
        request(1'b0, 32'hBFC0_0900, 8'd7);
        addr_phase(0, t, ok);
        if (ok) begin
            burst(t, 7, 0, 1'b0, -1, hs);
            chk("t5b_handshakes", hs, 8);
        end
        repeat (2) step();
        chk("t5b_err_held", bus.err, 1);
        do_reset();

        // 6: reset during beat 3 of an INST burst
        push(1'b0, 32'hBFC0_0A00, 8'd7);
        request(1'b0, 32'hBFC0_0A00, 8'd7);
        addr_phase(0, t, ok);
        if (ok) begin
            burst(t, 7, -1, 1'b0, 3, hs);
            chk("t6_pre_reset_hs", hs, 3);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        #1;
        chk_reset_outputs();
        rst = 1'b1;
        last_g = 1'b0;
        err_model = 1'b0;
        sb.delete();
        step();
        push(1'b0, 32'hBFC0_0B00, 8'd7);
        request(1'b0, 32'hBFC0_0B00, 8'd7);
        serve(0);
        #1;
        chk("t6_err", bus.err, 0);
        chk("t6_busy", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
